// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared encodings for the parametrised UART receiver  (rev 1.0)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int MIN_BAUD_DIV = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_DELIVER = 3'd5
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_sync : two-flop line synchroniser with falling-edge pulse  (rev 1.0)
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // prev_q only goes high once sync_q holds a genuinely sampled 1, so a line
    // that is already low coming out of reset never produces a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b0;
            fill_q <= 2'b00;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            fill_q <= {fill_q[0], 1'b1};
            prev_q <= sync_q & fill_q[1];
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_param : parametrised UART receiver with parity/framing/break and
//                 valid/ready output register                        (rev 1.0)
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 baud_div_load,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 out_break,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic                 busy
);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx_in),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    logic [DIV_W-1:0] baud_div_d;
    logic [DIV_W-1:0] div_reg_q;

    assign baud_div_d = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg_q <= DIV_W'(MIN_BAUD_DIV);
        end else if (baud_div_load) begin
            div_reg_q <= baud_div_d;
        end
    end

    rx_state_e            state_q;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     half;
    logic [1:0]           pmode_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 par_bit_q;
    logic                 frame_err_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 out_parity_err_q;
    logic                 out_frame_err_q;
    logic                 out_break_q;
    logic                 overrun_q;
    logic                 par_en;
    logic                 accept;
    logic                 period_end;

    assign half       = div_q >> 1;
    assign par_en     = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    assign accept     = out_valid_q & out_ready;
    assign period_end = (cnt_q == div_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            div_q            <= DIV_W'(MIN_BAUD_DIV);
            cnt_q            <= '0;
            pmode_q          <= PAR_NONE;
            bit_cnt_q        <= 4'd0;
            shift_q          <= '0;
            par_err_q        <= 1'b0;
            par_bit_q        <= 1'b0;
            frame_err_q      <= 1'b0;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            out_parity_err_q <= 1'b0;
            out_frame_err_q  <= 1'b0;
            out_break_q      <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q      <= 1'b0;
                out_parity_err_q <= 1'b0;
                out_frame_err_q  <= 1'b0;
                out_break_q      <= 1'b0;
            end
            if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state_q     <= ST_START;
                        cnt_q       <= '0;
                        bit_cnt_q   <= 4'd0;
                        div_q       <= div_reg_q;
                        pmode_q     <= parity_mode;
                        par_err_q   <= 1'b0;
                        par_bit_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end

                ST_START: begin
                    if (cnt_q == half) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end

                ST_DATA: begin
                    if (period_end) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (period_end) begin
                        cnt_q     <= '0;
                        par_bit_q <= rx_s;
                        // Even: error on XOR=1; odd: error on XOR=0.
                        par_err_q <= (^shift_q) ^ rx_s ^ (pmode_q == PAR_ODD);
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end

                ST_STOP: begin
                    if (period_end) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                        end
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            state_q <= ST_DELIVER;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end

                ST_DELIVER: begin
                    // A word still waiting for the consumer is never overwritten.
                    if (!out_valid_q || out_ready) begin
                        out_data_q       <= shift_q;
                        out_valid_q      <= 1'b1;
                        out_parity_err_q <= par_err_q;
                        out_frame_err_q  <= frame_err_q;
                        out_break_q      <= frame_err_q & ~(|shift_q) & ~par_bit_q;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_parity_err = out_parity_err_q;
    assign out_frame_err  = out_frame_err_q;
    assign out_break      = out_break_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire
